// File: rtl/aes_inv_mcol_iter.sv
// aes_inv_mcol_iter: iterative AES InvMixColumns, one column per clock,
// valid/ready on both sides. Nb comes from the aes_const package below.
package aes_const;
   localparam int Nb = 4;
endpackage

module aes_inv_mcol_iter
   import aes_const::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       valid_in,
   output logic       ready_in,
   input  logic [7:0] State_in [0:4*Nb-1],
   output logic       valid_out,
   input  logic       ready_out,
   output logic [7:0] State_out [0:4*Nb-1]
);
   localparam int CW = (Nb > 1) ? $clog2(Nb) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          valid_q;
   logic [7:0]    st_q [0:4*Nb-1];
   logic [7:0]    a [4];
   logic [7:0]    col [4];
   logic          last;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // k selects which of b, x2, x4, x8 are summed (0x09/0x0B/0x0D/0x0E)
   function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xt(b);
      x4 = xt(x2);
      x8 = xt(x4);
      return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) a[i] = 8'h00;
      for (int j = 0; j < Nb; j++)
         for (int i = 0; i < 4; i++)
            if (cnt_q == CW'(j)) a[i] = st_q[4*j+i];
      for (int i = 0; i < 4; i++)
         col[i] = gmul(a[i], 4'hE) ^ gmul(a[(i+1)%4], 4'hB) ^ gmul(a[(i+2)%4], 4'hD) ^ gmul(a[(i+3)%4], 4'h9);
   end

   assign last      = cnt_q == CW'(Nb-1);
   assign ready_in  = (state_q == IDLE) || (state_q == DONE && ready_out);
   assign valid_out = valid_q;
   assign State_out = st_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         for (int k = 0; k < 4*Nb; k++) st_q[k] <= 8'h00;
      end else begin
         case (state_q)
            IDLE: if (valid_in) begin
               st_q    <= State_in;
               cnt_q   <= '0;
               state_q <= BUSY;
            end
            BUSY: begin
               for (int j = 0; j < Nb; j++)
                  for (int i = 0; i < 4; i++)
                     if (cnt_q == CW'(j)) st_q[4*j+i] <= col[i];
               cnt_q <= last ? '0 : cnt_q + CW'(1);
               if (last) begin
                  state_q <= DONE;
                  valid_q <= 1'b1;
               end
            end
            DONE: if (ready_out) begin
               valid_q <= 1'b0;
               state_q <= IDLE;
               if (valid_in) begin
                  st_q    <= State_in;
                  cnt_q   <= '0;
                  state_q <= BUSY;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_inv_mcol_iter.sv
// tb_aes_inv_mcol_iter: directed checks of aes_inv_mcol_iter against
// hand-computed vectors and a forward-MixColumns round trip.
module tb_aes_inv_mcol_iter;
   import aes_const::*;
   logic       clock = 1'b0;
   logic       reset;
   logic       valid_in;
   logic       ready_in;
   logic [7:0] st_in  [0:4*Nb-1];
   logic       valid_out;
   logic       ready_out;
   logic [7:0] st_out [0:4*Nb-1];
   int total = 0, passed = 0, fails = 0;

   aes_inv_mcol_iter dut (
      .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
      .State_in(st_in), .valid_out(valid_out), .ready_out(ready_out), .State_out(st_out)
   );

   always #5 clock = ~clock;

   function automatic logic [127:0] pack(input logic [7:0] s [0:15]);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[k];
      return r;
   endfunction

   function automatic logic [7:0] x2(input logic [7:0] b);
      return b[7] ? ({b[6:0], 1'b0} ^ 8'h1B) : {b[6:0], 1'b0};
   endfunction

   function automatic logic [127:0] fwd_mix(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      for (int j = 0; j < 4; j++) begin
         {a0, a1, a2, a3} = s[127-32*j -: 32];
         r[127-32*j -: 32] = {x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3,
                              x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3)};
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [127:0] v);
      for (int k = 0; k < 16; k++) st_in[k] = v[127-8*k -: 8];
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [127:0] v, output logic [127:0] r, output int lat);
      load(v);
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      lat = 0;
      while (valid_out !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      r = pack(st_out);
      ready_out = 1'b1;
      step();
      ready_out = 1'b0;
   endtask

   localparam logic [127:0] MIX_IN  = 128'h8E4DA1BC_9FDC589D_D5D5D7D6_4D7EBDF8;
   localparam logic [127:0] MIX_OUT = 128'hDB135345_F20A225C_D4D4D4D5_2D26314C;

   initial begin
      logic [31:0]  cin  [6];
      logic [31:0]  cout [6];
      logic [127:0] r, o, f;
      int lat;
      cin  = '{32'h8E4DA1BC, 32'h9FDC589D, 32'hD5D5D7D6, 32'h4D7EBDF8, 32'h01010101, 32'h00000000};
      cout = '{32'hDB135345, 32'hF20A225C, 32'hD4D4D4D5, 32'h2D26314C, 32'h01010101, 32'h00000000};
      reset = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
      load('0);
      repeat (3) step();
      chk("rst_valid_out", 128'(valid_out), 128'd0);
      chk("rst_state_out", pack(st_out), 128'd0);
      reset = 1'b1;
      step();
      chk("rst_ready_in", 128'(ready_in), 128'd1);

      for (int v = 0; v < 6; v++) begin
         xfer({4{cin[v]}}, r, lat);
         chk($sformatf("uniform%0d", v), r, {4{cout[v]}});
         chk($sformatf("uniform%0d_lat", v), 128'(lat), 128'(Nb));
      end

      xfer(MIX_IN, r, lat);
      chk("mixed", r, MIX_OUT);
      chk("mixed_lat", 128'(lat), 128'(Nb));
      chk("idle_after_hs", 128'(valid_out), 128'd0);

      load({4{cin[1]}});
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      repeat (Nb) step();
      chk("bp_valid_rise", 128'(valid_out), 128'd1);
      for (int k = 0; k < 10; k++) begin
         valid_in = k[0];
         load({$urandom, $urandom, $urandom, $urandom});
         step();
         chk($sformatf("bp%0d_valid", k), 128'(valid_out), 128'd1);
         chk($sformatf("bp%0d_ready_in", k), 128'(ready_in), 128'd0);
         chk($sformatf("bp%0d_state", k), pack(st_out), {4{cout[1]}});
      end
      valid_in = 1'b0;
      ready_out = 1'b1;
      step();
      ready_out = 1'b0;
      chk("bp_release_valid", 128'(valid_out), 128'd0);
      chk("bp_release_ready", 128'(ready_in), 128'd1);

      load({4{cin[0]}});
      valid_in = 1'b1;
      ready_out = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         if (k < 2) load({4{cin[k+1]}});
         else valid_in = 1'b0;
         repeat (Nb) step();
         chk($sformatf("b2b%0d_valid", k), 128'(valid_out), 128'd1);
         chk($sformatf("b2b%0d_ready_in", k), 128'(ready_in), 128'd1);
         chk($sformatf("b2b%0d_state", k), pack(st_out), {4{cout[k]}});
         step();
      end
      ready_out = 1'b0;
      chk("b2b_end_valid", 128'(valid_out), 128'd0);

      for (int n = 0; n < 1000; n++) begin
         o = {$urandom, $urandom, $urandom, $urandom};
         f = fwd_mix(o);
         xfer(f, r, lat);
         chk($sformatf("roundtrip%0d", n), r, o);
      end

      load(MIX_IN);
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      #1;
      chk("midrst_valid", 128'(valid_out), 128'd0);
      chk("midrst_state", pack(st_out), 128'd0);
      step();
      reset = 1'b1;
      step();
      chk("postrst_ready_in", 128'(ready_in), 128'd1);
      chk("postrst_valid", 128'(valid_out), 128'd0);
      chk("postrst_state", pack(st_out), 128'd0);
      xfer(MIX_IN, r, lat);
      chk("postrst_xfer", r, MIX_OUT);
      chk("postrst_lat", 128'(lat), 128'(Nb));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
